// File: rtl/parking_gate_sensor_if.sv
// Lane sensor bundle: raw beam-break inputs toward the gate front end and the
// qualified passage / status outputs toward the parking controller.
interface parking_gate_sensor_if;
    logic beam_a;
    logic beam_b;
    logic car_enter;
    logic car_exit;
    logic lane_busy;
    logic fault;

    modport master (
        output beam_a,
        output beam_b,
        input  car_enter,
        input  car_exit,
        input  lane_busy,
        input  fault
    );

    modport slave (
        input  beam_a,
        input  beam_b,
        output car_enter,
        output car_exit,
        output lane_busy,
        output fault
    );
endinterface

// File: rtl/parking_gate_sensor.sv
// Gate lane front end: synchronises and debounces the two IR beams, decodes the
// beam order into entry/exit passages and emits one stretched pulse per car.
//
// state  | meaning
// IDLE   | lane clear, waiting for a beam
// EN_A   | entering, street beam only
// EN_AB  | entering, both beams blocked
// EN_B   | entering, lot beam only
// EX_B   | exiting, lot beam only
// EX_BA  | exiting, both beams blocked
// EX_A   | exiting, street beam only
// FAULT  | illegal order or stall, wait for lane to clear
module parking_gate_sensor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    parking_gate_sensor_if.slave lane
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW  = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_BA = 3'd5,
        EX_A  = 3'd6,
        FAULT = 3'd7
    } state_t;

    // Bit 1 carries beam A, bit 0 beam B, so filt_q reads directly as {fa,fb}.
    logic [1:0]          meta_q;
    logic [1:0]          sync_q;
    logic [1:0]          filt_q;
    logic [1:0]          filt_d;
    logic [1:0][DBW-1:0] db_cnt_q;
    logic [1:0][DBW-1:0] db_cnt_d;

    state_t              state_q;
    state_t              state_d;
    logic [TOW-1:0]      to_cnt_q;
    logic [TOW-1:0]      to_cnt_d;
    logic                timeout_hit;

    logic                enter_q;
    logic                enter_d;
    logic                exit_q;
    logic                exit_d;
    logic [PW-1:0]       str_cnt_q;
    logic [PW-1:0]       str_cnt_d;
    logic                done_enter;
    logic                done_exit;

    logic                lane_busy_q;
    logic                fault_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {lane.beam_a, lane.beam_b};
            sync_q <= meta_q;
        end
    end

    // The counter reaches DEBOUNCE_CYCLES first; the filtered value follows one
    // cycle later, giving the synced level DEBOUNCE_CYCLES+1 samples of hold.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES)) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign timeout_hit = (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        done_enter = 1'b0;
        done_exit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                case (filt_q)
                    2'b10:   state_d = EN_A;
                    2'b01:   state_d = EX_B;
                    2'b11:   state_d = FAULT;
                    default: state_d = IDLE;
                endcase
            end
            EN_A: begin
                case (filt_q)
                    2'b11:   state_d = EN_AB;
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = FAULT;
                    default: state_d = EN_A;
                endcase
            end
            EN_AB: begin
                case (filt_q)
                    2'b01:   state_d = EN_B;
                    2'b10:   state_d = EN_A;
                    2'b00:   state_d = FAULT;
                    default: state_d = EN_AB;
                endcase
            end
            EN_B: begin
                case (filt_q)
                    2'b00: begin
                        state_d    = IDLE;
                        done_enter = 1'b1;
                    end
                    2'b11:   state_d = EN_AB;
                    2'b10:   state_d = FAULT;
                    default: state_d = EN_B;
                endcase
            end
            EX_B: begin
                case (filt_q)
                    2'b11:   state_d = EX_BA;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = FAULT;
                    default: state_d = EX_B;
                endcase
            end
            EX_BA: begin
                case (filt_q)
                    2'b10:   state_d = EX_A;
                    2'b01:   state_d = EX_B;
                    2'b00:   state_d = FAULT;
                    default: state_d = EX_BA;
                endcase
            end
            EX_A: begin
                case (filt_q)
                    2'b00: begin
                        state_d   = IDLE;
                        done_exit = 1'b1;
                    end
                    2'b11:   state_d = EX_BA;
                    2'b01:   state_d = FAULT;
                    default: state_d = EX_A;
                endcase
            end
            FAULT: begin
                if (filt_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stall only wins when no legal move is happening this cycle.
        if ((state_d == state_q) && (state_q != IDLE) && (state_q != FAULT) && timeout_hit) begin
            state_d = FAULT;
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == FAULT)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TOW'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // A completion always reloads the stretch and silences the opposite pulse.
    always_comb begin
        enter_d   = enter_q;
        exit_d    = exit_q;
        str_cnt_d = str_cnt_q;
        if (enter_q || exit_q) begin
            if (str_cnt_q >= PW'(PULSE_CYCLES)) begin
                enter_d   = 1'b0;
                exit_d    = 1'b0;
                str_cnt_d = '0;
            end else begin
                str_cnt_d = str_cnt_q + 1'b1;
            end
        end
        if (done_enter) begin
            enter_d   = 1'b1;
            exit_d    = 1'b0;
            str_cnt_d = PW'(1);
        end else if (done_exit) begin
            enter_d   = 1'b0;
            exit_d    = 1'b1;
            str_cnt_d = PW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            str_cnt_q   <= '0;
            lane_busy_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            enter_q     <= enter_d;
            exit_q      <= exit_d;
            str_cnt_q   <= str_cnt_d;
            lane_busy_q <= (state_d != IDLE);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign lane.car_enter = enter_q;
    assign lane.car_exit  = exit_q;
    assign lane.lane_busy = lane_busy_q;
    assign lane.fault     = fault_q;

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Bench for parking_gate_sensor: directed passages plus randomized lane traffic,
// checked every cycle against a lane-position model on two pulse-width variants.
module tb_parking_gate_sensor;

    localparam int DEB = 4;
    localparam int TMO = 64;
    localparam int P5  = 5;
    localparam int HL  = DEB + 3;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic raw_a  = 1'b0;
    logic raw_b  = 1'b0;
    logic ideal_a = 1'b0;
    logic ideal_b = 1'b0;

    int total = 0;
    int bad   = 0;

    parking_gate_sensor_if if1 ();
    parking_gate_sensor_if if5 ();

    assign if1.beam_a = raw_a;
    assign if1.beam_b = raw_b;
    assign if5.beam_a = raw_a;
    assign if5.beam_b = raw_b;

    parking_gate_sensor #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .PULSE_CYCLES(1)) dut1 (
        .clk_in (clk_in),
        .reset  (reset),
        .lane   (if1.slave)
    );

    parking_gate_sensor #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .PULSE_CYCLES(P5)) dut5 (
        .clk_in (clk_in),
        .reset  (reset),
        .lane   (if5.slave)
    );

    always #5 clk_in = ~clk_in;

    // Model: mode 0 idle, 1 entering, 2 exiting, 3 fault; pos 1..3 is how far
    // along the lane the car is in its direction of travel.
    logic [1:0] hist [HL];
    int mode = 0;
    int pos  = 0;
    int dwell = 0;
    int left_en1 = 0, left_ex1 = 0, left_en5 = 0, left_ex5 = 0;

    int n_en1 = 0, n_ex1 = 0, n_en5 = 0, n_ex5 = 0, n_busy = 0, n_fault = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int posof(input logic [1:0] p, input int dir);
        if (p == 2'b00) return 0;
        if (p == 2'b11) return 2;
        if (dir == 1) return (p == 2'b10) ? 1 : 3;
        return (p == 2'b01) ? 1 : 3;
    endfunction

    task automatic model_edge();
        logic [1:0] p;
        int np;
        int old_mode;
        int old_pos;
        if (reset) begin
            for (int i = 0; i < HL; i++) hist[i] = 2'b00;
            mode = 0; pos = 0; dwell = 0;
            left_en1 = 0; left_ex1 = 0; left_en5 = 0; left_ex5 = 0;
            return;
        end
        p = hist[HL-1];
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {ideal_a, ideal_b};
        if (left_en1 > 0) left_en1--;
        if (left_ex1 > 0) left_ex1--;
        if (left_en5 > 0) left_en5--;
        if (left_ex5 > 0) left_ex5--;
        old_mode = mode;
        old_pos  = pos;
        case (mode)
            0: begin
                if (p == 2'b10) begin mode = 1; pos = 1; end
                else if (p == 2'b01) begin mode = 2; pos = 1; end
                else if (p == 2'b11) mode = 3;
            end
            3: if (p == 2'b00) mode = 0;
            default: begin
                np = posof(p, mode);
                if (np == pos) begin
                end else if (pos == 3 && np == 0) begin
                    if (mode == 1) begin
                        left_en1 = 1; left_ex1 = 0; left_en5 = P5; left_ex5 = 0;
                    end else begin
                        left_ex1 = 1; left_en1 = 0; left_ex5 = P5; left_en5 = 0;
                    end
                    mode = 0;
                end else if (pos == 1 && np == 0) begin
                    mode = 0;
                end else if (np != 0 && (np - pos == 1 || pos - np == 1)) begin
                    pos = np;
                end else begin
                    mode = 3;
                end
            end
        endcase
        if (mode != old_mode || pos != old_pos || mode == 0 || mode == 3) begin
            dwell = 0;
        end else begin
            dwell++;
            if (dwell == TMO) begin
                mode  = 3;
                dwell = 0;
            end
        end
    endtask

    task automatic step_cycle();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        chk("enter1", if1.car_enter, left_en1 > 0);
        chk("exit1",  if1.car_exit,  left_ex1 > 0);
        chk("enter5", if5.car_enter, left_en5 > 0);
        chk("exit5",  if5.car_exit,  left_ex5 > 0);
        chk("busy1",  if1.lane_busy, mode != 0);
        chk("fault1", if1.fault,     mode == 3);
        chk("busy5",  if5.lane_busy, mode != 0);
        chk("fault5", if5.fault,     mode == 3);
        n_en1   += int'(if1.car_enter);
        n_ex1   += int'(if1.car_exit);
        n_en5   += int'(if5.car_enter);
        n_ex5   += int'(if5.car_exit);
        n_busy  += int'(if1.lane_busy);
        n_fault += int'(if1.fault);
    endtask

    task automatic clear_obs();
        n_en1 = 0; n_ex1 = 0; n_en5 = 0; n_ex5 = 0; n_busy = 0; n_fault = 0;
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        ideal_a = a; ideal_b = b;
        raw_a   = a; raw_b   = b;
        repeat (n) step_cycle();
    endtask

    task automatic glitch(input bit on_b, input int n);
        if (on_b) raw_b = ~ideal_b;
        else      raw_a = ~ideal_a;
        repeat (n) step_cycle();
        raw_a = ideal_a;
        raw_b = ideal_b;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) step_cycle();
        reset = 1'b0;
    endtask

    task automatic phase(input logic [1:0] p);
        int len;
        len = $urandom_range(10, 25);
        if ($urandom_range(0, 3) == 0) begin
            hold(p[1], p[0], 7);
            glitch(1'($urandom_range(0, 1)), $urandom_range(1, 3));
            hold(p[1], p[0], len - 7);
        end else begin
            hold(p[1], p[0], len);
        end
    endtask

    initial begin
        logic [1:0] seq [$];
        int kind;

        apply_reset(3);
        chk("rst_enter", if1.car_enter, 1'b0);
        chk("rst_exit",  if1.car_exit,  1'b0);
        chk("rst_busy",  if1.lane_busy, 1'b0);
        chk("rst_fault", if1.fault,     1'b0);

        clear_obs();
        hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
        chk("entry_n_enter1", n_en1, 1);
        chk("entry_n_enter5", n_en5, P5);
        chk("entry_n_exit",   n_ex1 + n_ex5, 0);
        chk("entry_n_busy",   n_busy, 60);

        clear_obs();
        hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20); hold(0, 0, 20);
        chk("exit_n_exit1",  n_ex1, 1);
        chk("exit_n_exit5",  n_ex5, P5);
        chk("exit_n_enter",  n_en1 + n_en5, 0);

        clear_obs();
        hold(1, 0, 20); hold(0, 0, 20);
        glitch(1'b1, 3);
        hold(0, 0, 20);
        chk("backout_pulses", n_en1 + n_ex1 + n_en5 + n_ex5, 0);
        chk("backout_fault",  n_fault, 0);
        chk("backout_busy",   n_busy, 20);
        chk("backout_idle",   if1.lane_busy, 1'b0);

        clear_obs();
        hold(1, 1, 20); hold(0, 0, 20);
        chk("both_n_fault",  n_fault, 20);
        chk("both_pulses",   n_en1 + n_ex1, 0);
        chk("both_idle",     if1.fault, 1'b0);

        clear_obs();
        hold(1, 0, 100); hold(0, 0, 20);
        chk("tmo_n_fault", n_fault, 36);
        chk("tmo_n_busy",  n_busy, 100);
        chk("tmo_pulses",  n_en1 + n_ex1, 0);

        clear_obs();
        hold(1, 0, 20); hold(1, 1, 15);
        apply_reset(1);
        chk("midrst_busy",  if5.lane_busy, 1'b0);
        chk("midrst_enter", if5.car_enter, 1'b0);
        hold(0, 1, 20); hold(0, 0, 20);
        chk("midrst_pulses", n_en5 + n_ex5, 0);
        clear_obs();
        hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
        chk("p5_n_enter5", n_en5, P5);
        chk("p5_n_enter1", n_en1, 1);

        for (int it = 0; it < 40; it++) begin
            seq.delete();
            kind = $urandom_range(0, 4);
            case (kind)
                0: seq = '{2'b10, 2'b11, 2'b01, 2'b00};
                1: seq = '{2'b01, 2'b11, 2'b10, 2'b00};
                2: seq = '{2'b10, 2'b00, 2'b01, 2'b00};
                3: begin
                    for (int k = 0; k < 3; k++) seq.push_back(2'($urandom_range(0, 3)));
                    seq.push_back(2'b00);
                end
                default: seq = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
            endcase
            foreach (seq[k]) phase(seq[k]);
            if ($urandom_range(0, 9) == 0) apply_reset(1);
        end
        hold(0, 0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
